stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM for the two-digit 00–99 seconds display path.
- Sequences the seconds count from two pushbuttons, START/STOP and LAP/CLEAR, each debounced and edge-detected internally.
- Consumes the existing 1 Hz single-cycle tick from the counter block.
- Outputs BCD digits for the downstream 7-segment decoders, plus status flags.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a key level change. Board builds override this to 500000.
- ALARM_SEC, default 60: alarm threshold as binary 0–99. Used only when the alarm macro is defined.

Ports:
- clk  in  1  system clock
- resetb  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle pulse per second from the counter block
- key_start_n  in  1  raw START/STOP pushbutton, active-low, asynchronous
- key_lap_n  in  1  raw LAP/CLEAR pushbutton, active-low, asynchronous
- disp_ones  out  4  BCD ones digit to display (0–9)
- disp_tens  out  4  BCD tens digit to display (0–9)
- running  out  1  count advancing (state RUN or LAP)
- lap_active  out  1  display frozen on lap value (state LAP)
- state  out  2  FSM state encoding
- wrap  out  1  one-cycle pulse when the count goes 99→00
- alarm  out  1  alarm flag; tied 0 when the feature is compiled out

Behaviour:
- Reset (async, resetb=0):
  - state=IDLE; live count, lap register, disp_*, wrap and alarm all 0.
  - Debouncers reset to the "released, armed" condition.
- Key path, per key:
  - 2-flop synchronizer, then debounce counter.
  - A press pulse (1 cycle) is issued when the synchronized level has been low for DEBOUNCE_CYCLES consecutive cycles while armed; the key then disarms.
  - The key re-arms only after DEBOUNCE_CYCLES consecutive synchronized-high cycles.
  - Holding a key yields exactly one press; glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM. States: IDLE=0, RUN=1, PAUSE=2, LAP=3. Transitions are taken on the edge after the press pulse.
  - IDLE: start→RUN; lap ignored.
  - RUN: start→PAUSE; lap→LAP, capturing the live count into the lap register that same edge.
  - LAP: start→PAUSE (display returns to live); lap→RUN.
  - PAUSE: start→RUN; lap→IDLE, clearing the live count to 00 on that edge.
  - Simultaneous start and lap presses in one cycle: start wins, lap is discarded.
- Counting:
  - Live count is two BCD digits.
  - On tick while the current (registered) state is RUN or LAP: ones+1; 9→0 with carry into tens; 99→00 with wrap=1 for that one cycle.
  - Tick in IDLE or PAUSE has no effect.
  - Tick coincident with a state-changing press: the increment follows the pre-transition state. For example, RUN with tick+start increments, then pauses. On PAUSE→IDLE the clear has priority over any tick.
- Display:
  - Registered, one cycle after the count or lap register update.
  - In LAP, disp_* shows the lap register; in every other state it shows the live count.
- No binary division or modulo anywhere; BCD arithmetic only. Digits never exceed 9.

Optional Feature:
- STOPWATCH_ALARM_EN defined:
  - alarm sets on the edge where the live count becomes equal to ALARM_SEC, converted to BCD at elaboration, due to a tick.
  - It stays set until the next accepted press of either key, or reset. A press and the set condition in the same cycle: set wins.
  - An ALARM_SEC value above 99 is clamped to 99.
- Not defined: alarm is constant 0; no compare logic is built.

Decomposition:
- Shared package stopwatch_pkg holds:
  - State encodings IDLE/RUN/PAUSE/LAP.
  - The BCD max digit constant 9.
  - The 7-segment active-low digit patterns, shared with the display decoders.
- Natural sub-module key_debounce (synchronizer, debounce counter, arm/press pulse), instantiated twice. The counter width is derived from DEBOUNCE_CYCLES.

Test Plan:
Run with DEBOUNCE_CYCLES=4 and ALARM_SEC=5.
- Reset then idle: 10 ticks → disp=00, state=0, running=0.
- Start press held 20 cycles then released, then 12 ticks → exactly one transition to RUN; disp=12; running=1.
- In RUN at count 07, lap press, then 3 ticks → disp holds 07, lap_active=1. Second lap press → disp=10.
- Count at 99 in RUN, tick → disp=00, wrap=1 for exactly one cycle.
- 2-cycle low glitch on key_start_n in IDLE → no state change. Start and lap pressed same cycle in RUN → PAUSE; lap register unchanged.
- Alarm (macro defined): ticks to 05 → alarm=1 and held through a further tick; start press clears alarm and enters PAUSE. resetb asserted mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM encodings, BCD helpers, 7-segment patterns.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Active-low gfedcba patterns for digits 0..9
  localparam logic [6:0] SEG_N [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == BCD_MAX) begin
      r.ones = 4'd0;
      r.tens = (v.tens == BCD_MAX) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  // Elaboration-time binary to BCD by repeated subtraction, clamped to 0..99
  function automatic bcd2_t to_bcd(input int v);
    int    rem;
    bcd2_t r;
    rem = (v > 99) ? 99 : ((v < 0) ? 0 : v);
    r   = '0;
    for (int i = 0; i < 10; i++) begin
      if (rem >= 10) begin
        rem    = rem - 10;
        r.tens = r.tens + 4'd1;
      end
    end
    r.ones = rem[3:0];
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter, armed
// single-cycle press pulse.
module key_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic resetb,
  input  logic key_n,
  output logic press
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [1:0]   sync;
  logic         armed;
  logic [W-1:0] cnt;
  logic         moving;

  // Armed waits for a stable low, disarmed waits for a stable high
  assign moving = (sync[1] != armed);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync  <= 2'b11;
      armed <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (!moving) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        armed <= ~armed;
        press <= armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with BCD seconds count and lap hold.
// Optional alarm compare enabled by STOPWATCH_ALARM_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALARM_SEC       = 60
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       tick,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_tens,
  output logic       running,
  output logic       lap_active,
  output logic [1:0] state,
  output logic       wrap,
  output logic       alarm
);

  logic       start_p;
  logic       lap_p;
  logic       lap_ev;
  logic       inc;
  logic       clr;
  logic [1:0] state_nx;
  bcd2_t      live;
  bcd2_t      lap_q;
  bcd2_t      disp;
  bcd2_t      nxt;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk    (clk),
    .resetb (resetb),
    .key_n  (key_start_n),
    .press  (start_p)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk    (clk),
    .resetb (resetb),
    .key_n  (key_lap_n),
    .press  (lap_p)
  );

  // Start wins over a coincident lap press
  assign lap_ev = lap_p & ~start_p;
  assign inc    = tick & ((state == ST_RUN) | (state == ST_LAP));
  assign clr    = lap_ev & (state == ST_PAUSE);
  assign nxt    = bcd_inc(live);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start_p) state_nx = ST_RUN;
      ST_RUN:   if (start_p) state_nx = ST_PAUSE;
                else if (lap_ev) state_nx = ST_LAP;
      ST_LAP:   if (start_p) state_nx = ST_PAUSE;
                else if (lap_ev) state_nx = ST_RUN;
      ST_PAUSE: if (start_p) state_nx = ST_RUN;
                else if (lap_ev) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      live  <= '0;
      lap_q <= '0;
      disp  <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr)
        live <= '0;
      else if (inc)
        live <= nxt;
      if ((state == ST_RUN) && lap_ev)
        lap_q <= live;
      wrap <= inc && (live == {BCD_MAX, BCD_MAX});
      disp <= (state == ST_LAP) ? lap_q : live;
    end
  end

  assign disp_tens  = disp.tens;
  assign disp_ones  = disp.ones;
  assign running    = (state == ST_RUN) | (state == ST_LAP);
  assign lap_active = (state == ST_LAP);

`ifdef STOPWATCH_ALARM_EN
  localparam bcd2_t ALARM_BCD = to_bcd(ALARM_SEC);

  logic alarm_q;

  // A tick reaching the threshold beats a coincident key press
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      alarm_q <= 1'b0;
    else if (inc && (nxt == ALARM_BCD))
      alarm_q <= 1'b1;
    else if (start_p | lap_p)
      alarm_q <= 1'b0;
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^ALARM_SEC;
  assign alarm        = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed table-driven bench for stopwatch_ctrl (DEBOUNCE_CYCLES=4, ALARM_SEC=5).
module tb_stopwatch_ctrl;

  localparam int A_TICK   = 0;
  localparam int A_START  = 1;
  localparam int A_LAP    = 2;
  localparam int A_BOTH   = 3;
  localparam int A_GLITCH = 4;

  typedef struct {
    int         act;
    int         n;
    logic [1:0] st;
    logic [7:0] disp;
    logic       run;
    logic       lap;
  } vec_t;

  logic       clk;
  logic       resetb;
  logic       tick;
  logic       key_start_n;
  logic       key_lap_n;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;
  logic       running;
  logic       lap_active;
  logic [1:0] state;
  logic       wrap;
  logic       alarm;

  int n_run;
  int n_fail;
  vec_t tv[$];

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .ALARM_SEC       (5)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .tick        (tick),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .disp_ones   (disp_ones),
    .disp_tens   (disp_tens),
    .running     (running),
    .lap_active  (lap_active),
    .state       (state),
    .wrap        (wrap),
    .alarm       (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
    cyc(2);
  endtask

  task automatic press(input logic s, input logic l, input int hold);
    key_start_n = ~s;
    key_lap_n   = ~l;
    cyc(hold);
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    cyc(12);
  endtask

  task automatic apply(input vec_t v);
    case (v.act)
      A_TICK:   ticks(v.n);
      A_START:  press(1'b1, 1'b0, v.n);
      A_LAP:    press(1'b0, 1'b1, v.n);
      A_BOTH:   press(1'b1, 1'b1, v.n);
      A_GLITCH: press(1'b1, 1'b0, v.n);
      default:  cyc(1);
    endcase
  endtask

  initial begin
    n_run       = 0;
    n_fail      = 0;
    resetb      = 1'b0;
    tick        = 1'b0;
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;

    tv.push_back('{A_TICK,   10, 2'd0, 8'h00, 1'b0, 1'b0});
    tv.push_back('{A_START,  20, 2'd1, 8'h00, 1'b1, 1'b0});
    tv.push_back('{A_TICK,    7, 2'd1, 8'h07, 1'b1, 1'b0});
    tv.push_back('{A_LAP,    10, 2'd3, 8'h07, 1'b1, 1'b1});
    tv.push_back('{A_TICK,    3, 2'd3, 8'h07, 1'b1, 1'b1});
    tv.push_back('{A_LAP,    10, 2'd1, 8'h10, 1'b1, 1'b0});
    tv.push_back('{A_TICK,   12, 2'd1, 8'h22, 1'b1, 1'b0});
    tv.push_back('{A_START,  10, 2'd2, 8'h22, 1'b0, 1'b0});
    tv.push_back('{A_TICK,    5, 2'd2, 8'h22, 1'b0, 1'b0});
    tv.push_back('{A_LAP,    10, 2'd0, 8'h00, 1'b0, 1'b0});
    tv.push_back('{A_GLITCH,  2, 2'd0, 8'h00, 1'b0, 1'b0});
    tv.push_back('{A_START,  10, 2'd1, 8'h00, 1'b1, 1'b0});
    tv.push_back('{A_TICK,    3, 2'd1, 8'h03, 1'b1, 1'b0});
    tv.push_back('{A_LAP,    10, 2'd3, 8'h03, 1'b1, 1'b1});
    tv.push_back('{A_TICK,    2, 2'd3, 8'h03, 1'b1, 1'b1});
    tv.push_back('{A_BOTH,   10, 2'd2, 8'h05, 1'b0, 1'b0});
    tv.push_back('{A_START,  10, 2'd1, 8'h05, 1'b1, 1'b0});
    tv.push_back('{A_TICK,    2, 2'd1, 8'h07, 1'b1, 1'b0});
    tv.push_back('{A_BOTH,   10, 2'd2, 8'h07, 1'b0, 1'b0});
    tv.push_back('{A_START,  10, 2'd1, 8'h07, 1'b1, 1'b0});
    tv.push_back('{A_TICK,   92, 2'd1, 8'h99, 1'b1, 1'b0});

    cyc(3);
    chk("rst state", state, 2'd0);
    chk("rst disp", {disp_tens, disp_ones}, 8'h00);
    chk("rst wrap", wrap, 1'b0);
    chk("rst alarm", alarm, 1'b0);
    resetb = 1'b1;
    cyc(2);

    foreach (tv[i]) begin
      apply(tv[i]);
      chk($sformatf("row%0d state", i), state, tv[i].st);
      chk($sformatf("row%0d disp", i), {disp_tens, disp_ones}, tv[i].disp);
      chk($sformatf("row%0d running", i), running, tv[i].run);
      chk($sformatf("row%0d lap_active", i), lap_active, tv[i].lap);
    end

    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("wrap pulse", wrap, 1'b1);
    cyc(1);
    chk("wrap drop", wrap, 1'b0);
    chk("wrap disp", {disp_tens, disp_ones}, 8'h00);
    cyc(3);
    chk("wrap stays low", wrap, 1'b0);

    resetb = 1'b0;
    cyc(2);
    resetb = 1'b1;
    cyc(2);
    press(1'b1, 1'b0, 10);
    ticks(5);
    chk("alarm disp", {disp_tens, disp_ones}, 8'h05);
`ifdef STOPWATCH_ALARM_EN
    chk("alarm set", alarm, 1'b1);
    ticks(1);
    chk("alarm held", alarm, 1'b1);
`else
    chk("alarm off", alarm, 1'b0);
    ticks(1);
    chk("alarm off held", alarm, 1'b0);
`endif
    press(1'b1, 1'b0, 10);
    chk("alarm clr", alarm, 1'b0);
    chk("alarm pause", state, 2'd2);
    chk("alarm pause disp", {disp_tens, disp_ones}, 8'h06);

    press(1'b1, 1'b0, 10);
    ticks(2);
    chk("pre-rst disp", {disp_tens, disp_ones}, 8'h08);
    #2;
    resetb = 1'b0;
    #1;
    chk("async state", state, 2'd0);
    chk("async disp", {disp_tens, disp_ones}, 8'h00);
    chk("async running", running, 1'b0);
    chk("async lap", lap_active, 1'b0);
    chk("async wrap", wrap, 1'b0);
    chk("async alarm", alarm, 1'b0);
    cyc(2);
    resetb = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
